// File: rtl/red_pkg.sv
// Shared encodings for the reduced RISC-V front-end: opcodes, ALU/result
// select codes, immediate formats and the decoded control bundle.
package red_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       jalrctrl;
    logic       jump;
    logic       branch;
    logic       bne;
    logic       zero_rs1;
    logic [2:0] aluctrl;
    logic [1:0] resultsrc;
    logic       illegal;
  } ctrl_t;

  // Sign-extended immediate for the given RISC-V format.
  function automatic logic [31:0] imm_gen(input imm_t sel, input logic [31:0] w);
    logic [31:0] r;
    case (sel)
      IMM_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_J:   r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      IMM_U:   r = {w[31:12], 12'b0};
      default: r = {{20{w[31]}}, w[31:20]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/red_decoder.sv
// Combinational instruction decoder: one 32-bit word in, control bundle,
// immediate and illegal flag out. Validity gating happens in the front-end.
module red_decoder
  import red_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  imm_t       immsel;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm    = imm_gen(immsel, instr);

  always_comb begin
    ctrl           = '0;
    ctrl.aluctrl   = ALU_ADD;
    ctrl.resultsrc = RES_ALU;
    immsel         = IMM_I;
    case (opcode)
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.zero_rs1 = 1'b1;
        immsel        = IMM_U;
      end
      OP_IMM, OP_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = (opcode == OP_IMM);
        case (funct3)
          3'b000:  ctrl.aluctrl = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl.aluctrl = ALU_AND;
          3'b110:  ctrl.aluctrl = ALU_OR;
          3'b010:  ctrl.aluctrl = ALU_SLT;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.resultsrc = RES_MEM;
        ctrl.illegal   = (funct3 != 3'b010);
      end
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        immsel        = IMM_S;
        ctrl.illegal  = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.bne     = funct3[0];
        ctrl.aluctrl = ALU_SUB;
        immsel       = IMM_B;
        ctrl.illegal = (funct3[2:1] != 2'b00);
      end
      OP_JAL: begin
        ctrl.regwrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultsrc = RES_PC4;
        immsel         = IMM_J;
      end
      OP_JALR: begin
        ctrl.regwrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jalrctrl  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.resultsrc = RES_PC4;
        ctrl.illegal   = (funct3 != 3'b000);
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/red_frontend.sv
// Fetch/decode front-end: owns pc_f/pc_d, squashes the wrong-path word on
// a taken branch or jump, and counts retired instructions.
module red_frontend
  import red_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 5,
  parameter int                    ALUctrl_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     Zero,
  input  logic [DATA_WIDTH-1:0]    PCTarget,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic                     MemWrite,
  output logic                     ALUsrc,
  output logic                     JALRctrl,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic [1:0]               ResultSrc,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    PC,
  output logic [DATA_WIDTH-1:0]    PCPlus4,
  output logic                     illegal,
  output logic [31:0]              instret
);

  logic [DATA_WIDTH-1:0] pc_f_reg, pc_f_next, pc_d_reg;
  logic                  id_valid_reg;
  logic [31:0]           instret_reg;
  logic [31:0]           instr;
  logic [31:0]           dec_imm;
  ctrl_t                 dec;
  logic                  live, retire, taken, redirect;

  assign instr = imem_rdata[31:0];

  red_decoder u_decoder (
    .instr (instr),
    .ctrl  (dec),
    .imm   (dec_imm)
  );

  // rst is folded in so write-enables fall the instant reset rises.
  assign live     = id_valid_reg & ~rst;
  assign retire   = live & ~dec.illegal;
  assign taken    = dec.branch & (dec.bne ? ~Zero : Zero);
  assign redirect = retire & (taken | dec.jump);
  assign pc_f_next = redirect ? PCTarget : pc_f_reg + DATA_WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_reg     <= RESET_PC;
      pc_d_reg     <= RESET_PC;
      id_valid_reg <= 1'b0;
      instret_reg  <= '0;
    end else begin
      pc_f_reg     <= pc_f_next;
      pc_d_reg     <= pc_f_reg;
      id_valid_reg <= ~redirect;
      if (retire)
        instret_reg <= instret_reg + 32'd1;
    end
  end

  assign imem_addr = pc_f_reg;
  assign PC        = pc_d_reg;
  assign PCPlus4   = pc_d_reg + DATA_WIDTH'(4);
  assign instret   = instret_reg;

  assign RegWrite  = retire & dec.regwrite;
  assign MemWrite  = retire & dec.memwrite;
  assign JALRctrl  = retire & dec.jalrctrl;
  assign illegal   = live & dec.illegal;

  assign ALUsrc    = dec.alusrc;
  assign ALUctrl   = ALUctrl_WIDTH'(dec.aluctrl);
  assign ResultSrc = dec.resultsrc;
  assign ImmOp     = DATA_WIDTH'(signed'(dec_imm));

  assign rs1 = dec.zero_rs1 ? '0 : ADDRESS_WIDTH'(instr[19:15]);
  assign rs2 = ADDRESS_WIDTH'(instr[24:20]);
  assign rd  = ADDRESS_WIDTH'(instr[11:7]);

endmodule

// File: tb/tb_red_frontend.sv
// Directed + random bench for red_frontend against an ISA-level model of
// the fetch/decode behaviour (PC sequencing, squash, retire count).
module tb_red_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, PCTarget, ImmOp, PC, PCPlus4, instret;
  logic        Zero, RegWrite, MemWrite, ALUsrc, JALRctrl, illegal;
  logic [2:0]  ALUctrl;
  logic [1:0]  ResultSrc;
  logic [4:0]  rs1, rs2, rd;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pcf, m_pcd, m_instret;
  bit          m_valid;

  always #5 clk = ~clk;

  red_frontend dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .Zero(Zero), .PCTarget(PCTarget), .ImmOp(ImmOp), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUsrc(ALUsrc), .JALRctrl(JALRctrl), .ALUctrl(ALUctrl),
    .ResultSrc(ResultSrc), .rs1(rs1), .rs2(rs2), .rd(rd), .PC(PC),
    .PCPlus4(PCPlus4), .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    bit          legal, rw, mw, jalr, jump, beq, bne, lui;
    bit          c_src, c_alu, c_res, c_imm;
    bit          src;
    logic [2:0]  alu;
    logic [1:0]  res;
    logic [31:0] imm;
  } exp_t;

  // What the ISA says each instruction word means.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] i_imm;
    logic [12:0] b13;
    logic [20:0] j21;
    e     = '0;
    f3    = w[14:12];
    i_imm = 32'($signed(w) >>> 20);
    b13   = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21   = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (w[6:0])
      7'h37: begin
        e.legal = 1; e.rw = 1; e.lui = 1;
        e.c_src = 1; e.src = 1; e.c_alu = 1; e.alu = 3'b000;
        e.c_res = 1; e.res = 2'b00; e.c_imm = 1; e.imm = w & 32'hFFFFF000;
      end
      7'h13, 7'h33: begin
        e.legal = (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2);
        e.rw = 1; e.c_src = 1; e.src = (w[6:0] == 7'h13);
        e.c_alu = 1; e.c_res = 1; e.res = 2'b00;
        case (f3)
          3'd7:    e.alu = 3'b010;
          3'd6:    e.alu = 3'b011;
          3'd2:    e.alu = 3'b101;
          default: e.alu = (w[6:0] == 7'h33 && w[30]) ? 3'b001 : 3'b000;
        endcase
        e.c_imm = (w[6:0] == 7'h13); e.imm = i_imm;
      end
      7'h03: begin
        e.legal = (f3 == 3'd2); e.rw = 1;
        e.c_src = 1; e.src = 1; e.c_alu = 1; e.alu = 3'b000;
        e.c_res = 1; e.res = 2'b01; e.c_imm = 1; e.imm = i_imm;
      end
      7'h23: begin
        e.legal = (f3 == 3'd2); e.mw = 1;
        e.c_imm = 1; e.imm = (i_imm & ~32'h1F) | {27'd0, w[11:7]};
      end
      7'h63: begin
        e.legal = (f3 == 3'd0 || f3 == 3'd1);
        e.beq = (f3 == 3'd0); e.bne = (f3 == 3'd1);
        e.c_src = 1; e.src = 0; e.c_alu = 1; e.alu = 3'b001;
        e.c_imm = 1; e.imm = 32'($signed(b13));
      end
      7'h6F: begin
        e.legal = 1; e.rw = 1; e.jump = 1;
        e.c_res = 1; e.res = 2'b10; e.c_imm = 1; e.imm = 32'($signed(j21));
      end
      7'h67: begin
        e.legal = (f3 == 3'd0); e.rw = 1; e.jump = 1; e.jalr = 1;
        e.c_src = 1; e.src = 1; e.c_alu = 1; e.alu = 3'b000;
        e.c_res = 1; e.res = 2'b10; e.c_imm = 1; e.imm = i_imm;
      end
      default: e.legal = 0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pcf = 32'h0; m_pcd = 32'h0; m_valid = 0; m_instret = 32'h0;
  endtask

  // One decode cycle: drive the word, compare against the model, clock.
  task automatic cycle(input logic [31:0] w, input logic z, input logic [31:0] tgt);
    exp_t e;
    bit   vl, take;
    @(negedge clk);
    imem_rdata = w; Zero = z; PCTarget = tgt;
    #1;
    e    = ref_decode(w);
    vl   = m_valid && e.legal;
    take = vl && (e.jump || (e.beq && z) || (e.bne && !z));
    $display("cyc pc=%h word=%h valid=%0d zero=%0d tgt=%h redirect=%0d instret=%0d",
             m_pcd, w, m_valid, z, tgt, take, m_instret);
    check("imem_addr", imem_addr, m_pcf);
    check("PC", PC, m_pcd);
    check("PCPlus4", PCPlus4, m_pcd + 32'd4);
    check("instret", instret, m_instret);
    check("illegal", 32'(illegal), 32'(m_valid && !e.legal));
    check("RegWrite", 32'(RegWrite), 32'(vl && e.rw));
    check("MemWrite", 32'(MemWrite), 32'(vl && e.mw));
    check("JALRctrl", 32'(JALRctrl), 32'(vl && e.jalr));
    check("rd", 32'(rd), 32'(w[11:7]));
    check("rs2", 32'(rs2), 32'(w[24:20]));
    check("rs1", 32'(rs1), e.lui ? 32'd0 : 32'(w[19:15]));
    if (e.legal && e.c_src) check("ALUsrc", 32'(ALUsrc), 32'(e.src));
    if (e.legal && e.c_alu) check("ALUctrl", 32'(ALUctrl), 32'(e.alu));
    if (e.legal && e.c_res) check("ResultSrc", 32'(ResultSrc), 32'(e.res));
    if (e.legal && e.c_imm) check("ImmOp", ImmOp, e.imm);
    @(posedge clk);
    #1;
    m_pcd = m_pcf;
    m_pcf = take ? tgt : m_pcf + 32'd4;
    m_valid = !take;
    if (vl) m_instret = m_instret + 32'd1;
  endtask

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] w, r;
    ops = '{7'h37, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h0B};
    rst = 1'b1; imem_rdata = 32'h0; Zero = 1'b0; PCTarget = 32'h0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_MemWrite", 32'(MemWrite), 32'd0);
    check("rst_JALRctrl", 32'(JALRctrl), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    cycle(32'h00000013, 0, 32'h0);          // bubble right after reset
    cycle(32'h00500093, 0, 32'h0);          // addi x1,x0,5 at PC 0
    cycle(32'h008000EF, 0, 32'd12);         // jal at PC 4 -> 12
    check("jal_target", imem_addr, 32'd12);
    cycle(32'h00500093, 0, 32'h0);          // squashed slot
    cycle(32'h00000663, 1, 32'h20);         // beq taken
    check("beq_target", imem_addr, 32'h20);
    cycle(32'h00000013, 0, 32'h0);
    cycle(32'h00000663, 0, 32'h80);         // beq not taken
    check("beq_fallthru", imem_addr, 32'h28);
    cycle(32'h0020A223, 0, 32'h0);          // sw x2,4(x1)
    cycle(32'h123452B7, 0, 32'h0);          // lui x5,0x12345
    cycle(32'h0000007F, 0, 32'h0);          // unsupported opcode
    cycle(32'h00500093, 0, 32'h0);
    cycle(32'h00001063, 1, 32'h0);          // bne with Zero=1: not taken
    cycle(32'h00001063, 0, 32'h44);         // bne taken
    cycle(32'h00000013, 0, 32'h0);
    cycle(32'h000080E7, 0, 32'hFFFFFFFC);   // jalr to the top of memory
    cycle(32'h00000013, 0, 32'h0);
    cycle(32'h00100093, 0, 32'h0);
    check("pc_wrap", imem_addr, 32'h4);
    cycle(32'h0000006F, 0, m_pcf);          // redirect to the current pc_f
    cycle(32'h00000013, 0, 32'h0);
    cycle(32'h00000013, 0, 32'h0);

    // Asynchronous reset between edges while a valid ADDI is in D
    @(negedge clk);
    imem_rdata = 32'h00500093;
    #1;
    check("pre_rst_RegWrite", 32'(RegWrite), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_RegWrite", 32'(RegWrite), 32'd0);
    check("async_MemWrite", 32'(MemWrite), 32'd0);
    check("async_imem_addr", imem_addr, 32'h0);
    check("async_instret", instret, 32'd0);
    check("async_PC", PC, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    cycle(32'h00000013, 0, 32'h0);
    for (int i = 0; i < 10; i++) cycle(32'h00100093, 0, 32'h0);
    check("instret_ten", instret, 32'd10);

    // Random mix of legal and illegal words
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) begin
        case (w[6:0])
          7'h13, 7'h33: begin
            r = $urandom_range(0, 3);
            w[14:12] = (r == 0) ? 3'd0 : (r == 1) ? 3'd7 : (r == 2) ? 3'd6 : 3'd2;
          end
          7'h03, 7'h23: w[14:12] = 3'd2;
          7'h63:        w[14:12] = {2'b00, w[12]};
          7'h67:        w[14:12] = 3'd0;
          default: ;
        endcase
      end
      r = $urandom;
      cycle(w, 1'($urandom_range(0, 1)), {r[31:2], 2'b00});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
